soc_miner_rd_dma: RTL and testbench

- AXI read-DMA engine for the SoC miner.
- Sits between the register block (go, source_address, length) and the AXI memory master read channels (AR/R).
- On a go pulse it fetches `length` bytes from DRAM as a sequence of INCR bursts and presents the data as a 64-bit valid/ready stream to the downstream hashing datapath.
- The AW/W/B channels are outside this block.

---
 rtl/soc_miner_rd_dma_if.sv | 49 ++++
 rtl/soc_miner_rd_dma.sv | 152 +++++++++++++++
 tb/tb_soc_miner_rd_dma.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_miner_rd_dma_if.sv
// rtl/soc_miner_rd_dma_if.sv - AXI read channels (AR/R) and output data stream bundle for soc_miner_rd_dma
//
// master modport: the DMA engine (drives AR, rready, output stream)
// slave modport : memory + downstream sink (drives arready, R beats, Out_ready)
interface soc_miner_rd_dma_if #(
    parameter int MEMORY_DATA_WIDTH    = 64,
    parameter int MEMORY_ADDR_WIDTH    = 32,
    parameter int MEMORY_BUS_LEN_WIDTH = 4,
    parameter int MEMORY_ID_WIDTH      = 6
);
    logic                            m_memory_arvalid;
    logic                            m_memory_arready;
    logic [MEMORY_ADDR_WIDTH-1:0]    m_memory_araddr;
    logic [MEMORY_BUS_LEN_WIDTH-1:0] m_memory_arlen;
    logic [MEMORY_ID_WIDTH-1:0]      m_memory_arid;
    logic [2:0]                      m_memory_arsize;
    logic [1:0]                      m_memory_arburst;
    logic [1:0]                      m_memory_arlock;
    logic [3:0]                      m_memory_arcache;
    logic [2:0]                      m_memory_arprot;
    logic [3:0]                      m_memory_arqos;
    logic                            m_memory_rvalid;
    logic                            m_memory_rready;
    logic [MEMORY_DATA_WIDTH-1:0]    m_memory_rdata;
    logic                            m_memory_rlast;
    logic [1:0]                      m_memory_rresp;
    logic                            Out_valid;
    logic                            Out_ready;
    logic [63:0]                     Out_data;
    logic                            Out_last;

    modport master (
        output m_memory_arvalid, m_memory_araddr, m_memory_arlen, m_memory_arid,
               m_memory_arsize, m_memory_arburst, m_memory_arlock, m_memory_arcache,
               m_memory_arprot, m_memory_arqos, m_memory_rready,
               Out_valid, Out_data, Out_last,
        input  m_memory_arready, m_memory_rvalid, m_memory_rdata, m_memory_rlast,
               m_memory_rresp, Out_ready
    );

    modport slave (
        input  m_memory_arvalid, m_memory_araddr, m_memory_arlen, m_memory_arid,
               m_memory_arsize, m_memory_arburst, m_memory_arlock, m_memory_arcache,
               m_memory_arprot, m_memory_arqos, m_memory_rready,
               Out_valid, Out_data, Out_last,
        output m_memory_arready, m_memory_rvalid, m_memory_rdata, m_memory_rlast,
               m_memory_rresp, Out_ready
    );
endinterface

// File: rtl/soc_miner_rd_dma.sv
// rtl/soc_miner_rd_dma.sv - AXI read DMA: fetches Length bytes as INCR bursts into a 64-bit stream
//
// Ports:
//   Clk, Rst_n      clock, asynchronous active-low reset
//   Go              start pulse, ignored while Busy
//   Source_address  word pointer, byte address = {Source_address, 2'b00}, bit 0 ignored
//   Length          transfer length in bytes, low three bits discarded
//   Busy / Done     busy from accepted Go, one-cycle Done pulse as Busy falls
//   Error           sticky: bad rresp or rlast mismatch, cleared by next accepted Go
//   bus             AR/R channels and output stream (master side)
module soc_miner_rd_dma #(
    parameter int MEMORY_DATA_WIDTH    = 64,
    parameter int MEMORY_ADDR_WIDTH    = 32,
    parameter int MEMORY_BUS_LEN_WIDTH = 4,
    parameter int MEMORY_ID_WIDTH      = 6,
    parameter int RD_ID                = 0
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Go,
    input  logic [29:0] Source_address,
    input  logic [31:0] Length,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    soc_miner_rd_dma_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

    state_t      state, state_n;
    logic [31:0] addr, addr_n;
    logic [28:0] remaining, remaining_n;
    logic [4:0]  beat_cnt, beat_cnt_n;
    logic        error_q, error_n;
    logic        done_q, done_n;

    logic [9:0]  page_room;
    logic [4:0]  ar_beats;
    logic        r_xfer;
    logic        last_of_burst;
    logic        unused_inputs;

    assign unused_inputs = ^{Source_address[0], Length[2:0]};

    // Burst size: 16 beats max, never past the end of the transfer, and never
    // across a 4 KB page (page_room is 1..512 beats left in the current page).
    always_comb begin
        page_room = 10'd512 - {1'b0, addr[11:3]};
        ar_beats  = 5'd16;
        if (remaining < 29'd16) begin
            ar_beats = remaining[4:0];
        end
        if (page_room < {5'b0, ar_beats}) begin
            ar_beats = page_room[4:0];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            remaining <= remaining_n;
            beat_cnt  <= beat_cnt_n;
            error_q   <= error_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        state_n       = state;
        addr_n        = addr;
        remaining_n   = remaining;
        beat_cnt_n    = beat_cnt;
        error_n       = error_q;
        done_n        = 1'b0;
        bus.m_memory_arvalid = 1'b0;
        bus.m_memory_araddr  = addr;
        bus.m_memory_arlen   = '0;
        bus.m_memory_rready  = 1'b0;
        bus.Out_valid        = 1'b0;
        bus.Out_data         = '0;
        bus.Out_last         = 1'b0;
        r_xfer        = bus.m_memory_rvalid & bus.Out_ready;
        last_of_burst = (beat_cnt == 5'd1);

        case (state)
            S_IDLE: begin
                if (Go) begin
                    addr_n      = {Source_address[29:1], 3'b000};
                    remaining_n = Length[31:3];
                    beat_cnt_n  = '0;
                    error_n     = 1'b0;
                    state_n     = (Length[31:3] == 29'd0) ? S_DONE : S_AR;
                end
            end
            S_AR: begin
                bus.m_memory_arvalid = 1'b1;
                bus.m_memory_arlen   = MEMORY_BUS_LEN_WIDTH'(ar_beats - 5'd1);
                if (bus.m_memory_arready) begin
                    addr_n      = addr + {24'b0, ar_beats, 3'b000};
                    remaining_n = remaining - {24'b0, ar_beats};
                    beat_cnt_n  = ar_beats;
                    state_n     = S_R;
                end
            end
            S_R: begin
                // Straight pass-through: the sink's ready is the memory's ready.
                bus.m_memory_rready = bus.Out_ready;
                bus.Out_valid       = bus.m_memory_rvalid;
                bus.Out_data        = bus.m_memory_rdata;
                bus.Out_last        = bus.m_memory_rvalid & last_of_burst & (remaining == 29'd0);
                if (r_xfer) begin
                    if (bus.m_memory_rresp != 2'b00) begin
                        error_n = 1'b1;
                    end
                    if (bus.m_memory_rlast != last_of_burst) begin
                        error_n = 1'b1;
                    end
                    beat_cnt_n = beat_cnt - 5'd1;
                    // Our own beat count ends the burst; rlast is only cross-checked.
                    if (last_of_burst) begin
                        state_n = (remaining != 29'd0) ? S_AR : S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign Busy  = (state != S_IDLE);
    assign Done  = done_q;
    assign Error = error_q;

    assign bus.m_memory_arid    = MEMORY_ID_WIDTH'(RD_ID);
    assign bus.m_memory_arsize  = 3'b011;
    assign bus.m_memory_arburst = 2'b01;
    assign bus.m_memory_arlock  = 2'b00;
    assign bus.m_memory_arcache = 4'b0011;
    assign bus.m_memory_arprot  = 3'b000;
    assign bus.m_memory_arqos   = 4'b0000;
endmodule

// File: tb/tb_soc_miner_rd_dma.sv
// tb/tb_soc_miner_rd_dma.sv - self-checking bench for soc_miner_rd_dma
module tb_soc_miner_rd_dma;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Go;
    logic [29:0] Source_address;
    logic [31:0] Length;
    logic        Busy, Done, Error;

    always #5 Clk = ~Clk;

    soc_miner_rd_dma_if bus ();

    soc_miner_rd_dma dut (
        .Clk(Clk), .Rst_n(Rst_n), .Go(Go), .Source_address(Source_address), .Length(Length),
        .Busy(Busy), .Done(Done), .Error(Error), .bus(bus)
    );

    typedef struct {
        logic [31:0] byte_addr;
        logic [31:0] len;
        int          mode;        // 0 always ready, 1 random, 2 Out_ready 1,0,0,1
        int          err_beat;    // 1-based beat given rresp=2'b10, 0 = none
        bit          go_again;    // extra Go pulse while busy
        int          exp_ars;     // -1 = random vector, no fixed expectations
        int          exp_beats;
        logic [31:0] exp_ar0_addr;
        int          exp_ar0_len;
        logic        exp_err;
        int          exp_busy;    // -1 = don't care
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] data_of(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    // ---------------- bus agent: memory responder + stream sink + monitor ----------------
    bit          agent_en = 0;
    int          ready_mode = 0;
    int          err_beat = 0;
    int          cyc = 0;
    int          cur_left = 0;
    logic [31:0] cur_addr = '0;
    int          r_cnt = 0;
    bit          r_hold = 0;
    bit          prev_busy = 0;
    bit          prev_arvalid = 0;
    logic [31:0] prev_araddr = '0;
    logic [3:0]  prev_arlen = '0;
    logic [31:0] ar_addr_q[$];
    logic [3:0]  ar_len_q[$];
    logic [63:0] beat_q[$];
    bit          last_q[$];
    int done_cnt, busy_cnt, seq_err, pt_err, hold_err, attr_err, last_hs_cyc, first_done_cyc;

    task automatic clear_logs();
        ar_addr_q.delete(); ar_len_q.delete(); beat_q.delete(); last_q.delete();
        done_cnt = 0; busy_cnt = 0; seq_err = 0; pt_err = 0; hold_err = 0; attr_err = 0;
        last_hs_cyc = 0; first_done_cyc = 0; r_cnt = 0;
    endtask

    initial begin
        bus.m_memory_arready = 1'b0; bus.m_memory_rvalid = 1'b0; bus.m_memory_rdata = '0;
        bus.m_memory_rlast = 1'b0; bus.m_memory_rresp = 2'b00; bus.Out_ready = 1'b0;
        forever begin
            @(negedge Clk);
            cyc++;
            if (!agent_en) begin
                bus.m_memory_arready = 1'b0; bus.m_memory_rvalid = 1'b0; bus.m_memory_rlast = 1'b0;
                bus.Out_ready = 1'b0; cur_left = 0; r_hold = 0; prev_arvalid = 0; prev_busy = 0;
            end else begin
                bus.m_memory_arready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                case (ready_mode)
                    0: bus.Out_ready = 1'b1;
                    1: bus.Out_ready = 1'($urandom_range(0, 1));
                    default: bus.Out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                endcase
                if (cur_left > 0) begin
                    if (!r_hold) bus.m_memory_rvalid = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                    bus.m_memory_rdata = data_of(cur_addr);
                    bus.m_memory_rlast = (cur_left == 1);
                    bus.m_memory_rresp = (r_cnt + 1 == err_beat) ? 2'b10 : 2'b00;
                end else begin
                    bus.m_memory_rvalid = 1'b0; bus.m_memory_rlast = 1'b0; bus.m_memory_rresp = 2'b00;
                end
                #1;
                if (Busy) busy_cnt++;
                if (Done) begin
                    if (done_cnt == 0) first_done_cyc = cyc;
                    done_cnt++;
                    if (Busy || !prev_busy) seq_err++;
                end
                prev_busy = Busy;
                if (cur_left > 0) begin
                    if (bus.m_memory_rready !== bus.Out_ready || bus.Out_valid !== bus.m_memory_rvalid ||
                        (bus.m_memory_rvalid && bus.Out_data !== bus.m_memory_rdata)) pt_err++;
                end else if (bus.m_memory_rready !== 1'b0 || bus.Out_valid !== 1'b0 || bus.Out_last !== 1'b0) begin
                    pt_err++;
                end
                if (prev_arvalid && (bus.m_memory_arvalid !== 1'b1 || bus.m_memory_araddr !== prev_araddr ||
                                     bus.m_memory_arlen !== prev_arlen)) hold_err++;
                prev_arvalid = bus.m_memory_arvalid && !bus.m_memory_arready;
                prev_araddr  = bus.m_memory_araddr;
                prev_arlen   = bus.m_memory_arlen;
                r_hold = bus.m_memory_rvalid && !bus.m_memory_rready;
                if (bus.m_memory_rvalid && bus.m_memory_rready) begin
                    beat_q.push_back(bus.Out_data);
                    last_q.push_back(bus.Out_last);
                    cur_left--; cur_addr += 32'd8; r_cnt++; last_hs_cyc = cyc;
                end
                if (bus.m_memory_arvalid && bus.m_memory_arready) begin
                    ar_addr_q.push_back(bus.m_memory_araddr);
                    ar_len_q.push_back(bus.m_memory_arlen);
                    if (bus.m_memory_arid !== 6'd0 || bus.m_memory_arsize !== 3'b011 ||
                        bus.m_memory_arburst !== 2'b01 || bus.m_memory_arlock !== 2'b00 ||
                        bus.m_memory_arcache !== 4'b0011 || bus.m_memory_arprot !== 3'b000 ||
                        bus.m_memory_arqos !== 4'b0000) attr_err++;
                    cur_left = int'(bus.m_memory_arlen) + 1;
                    cur_addr = bus.m_memory_araddr;
                end
            end
        end
    end

    // ---------------- one transfer, checked against a burst-list model ----------------
    task automatic run_xfer(input vec_t v, input string tag);
        logic [31:0] a, start, rem, room, b;
        logic [31:0] exp_addr[$];
        int          exp_len[$];
        int          total, lat, data_bad, last_bad;
        logic        exp_err;
        bit          seen;

        start = v.byte_addr & 32'hFFFF_FFF8;
        a = start;
        rem = v.len / 32'd8;
        total = int'(rem);
        while (rem != 0) begin
            room = (32'd4096 - (a % 32'd4096)) / 32'd8;
            b = 32'd16;
            if (rem < b) b = rem;
            if (room < b) b = room;
            exp_addr.push_back(a);
            exp_len.push_back(int'(b) - 1);
            a = a + b * 32'd8;
            rem = rem - b;
        end
        exp_err = (v.err_beat >= 1) && (v.err_beat <= total);

        clear_logs();
        ready_mode = v.mode; err_beat = v.err_beat; agent_en = 1;
        @(negedge Clk);
        Source_address = v.byte_addr[31:2]; Length = v.len; Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        #2;
        check({tag, " busy_after_go"}, Busy, 1'b1);
        check({tag, " error_cleared_on_go"}, Error, 1'b0);
        seen = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge Clk); #2;
            if (v.go_again && t == 4) begin
                Source_address = 30'h0123_4560; Length = 32'd320; Go = 1'b1;
            end else begin
                Go = 1'b0;
            end
            if (done_cnt > 0) begin seen = 1; break; end
        end
        Go = 1'b0;
        check({tag, " done_seen_in_time"}, seen, 1'b1);
        repeat (3) @(negedge Clk);
        #2;

        check({tag, " ar_count"}, ar_addr_q.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < ar_addr_q.size(); i++) begin
            check($sformatf("%s ar%0d_addr", tag, i), ar_addr_q[i], exp_addr[i]);
            check($sformatf("%s ar%0d_len", tag, i), ar_len_q[i], exp_len[i]);
        end
        check({tag, " beat_count"}, beat_q.size(), total);
        data_bad = 0; last_bad = 0;
        for (int i = 0; i < beat_q.size(); i++) begin
            if (beat_q[i] !== data_of(start + 32'(i) * 32'd8)) data_bad++;
            if (last_q[i] !== (i == total - 1)) last_bad++;
        end
        check({tag, " data_errors"}, data_bad, 0);
        check({tag, " last_errors"}, last_bad, 0);
        check({tag, " error_flag"}, Error, exp_err);
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " busy_done_sequence_errors"}, seq_err, 0);
        check({tag, " passthrough_errors"}, pt_err, 0);
        check({tag, " ar_hold_errors"}, hold_err, 0);
        check({tag, " ar_attr_errors"}, attr_err, 0);
        if (total > 0) begin
            lat = first_done_cyc - last_hs_cyc;
            check({tag, " done_latency_1_or_2"}, (lat >= 1 && lat <= 2), 1'b1);
        end
        if (v.exp_ars >= 0) begin
            check({tag, " tbl_ar_count"}, ar_addr_q.size(), v.exp_ars);
            check({tag, " tbl_beats"}, beat_q.size(), v.exp_beats);
            check({tag, " tbl_error"}, Error, v.exp_err);
            if (v.exp_ars > 0 && ar_addr_q.size() > 0) begin
                check({tag, " tbl_ar0_addr"}, ar_addr_q[0], v.exp_ar0_addr);
                check({tag, " tbl_ar0_len"}, ar_len_q[0], v.exp_ar0_len);
            end
            if (v.exp_busy >= 0) check({tag, " tbl_busy_cycles"}, busy_cnt, v.exp_busy);
        end
    endtask

    vec_t tbl[9];
    vec_t rv;
    bit   got5;

    initial begin
        tbl[0] = '{32'h1000_0000, 32'd128, 0, 0, 1'b0, 1, 16, 32'h1000_0000, 15, 1'b0, -1};
        tbl[1] = '{32'h0000_0000, 32'd200, 1, 0, 1'b0, 2, 25, 32'h0000_0000, 15, 1'b0, -1};
        tbl[2] = '{32'h0000_0FF0, 32'd64,  0, 0, 1'b0, 2, 8,  32'h0000_0FF0, 1,  1'b0, -1};
        tbl[3] = '{32'h0000_0100, 32'd5,   0, 0, 1'b0, 0, 0,  32'h0,         0,  1'b0, 1};
        tbl[4] = '{32'h0000_3000, 32'd128, 2, 0, 1'b1, 1, 16, 32'h0000_3000, 15, 1'b0, -1};
        tbl[5] = '{32'h0000_4000, 32'd160, 1, 3, 1'b0, 2, 20, 32'h0000_4000, 15, 1'b1, -1};
        tbl[6] = '{32'hFFFF_FFC0, 32'd256, 1, 0, 1'b0, 3, 32, 32'hFFFF_FFC0, 7,  1'b0, -1};
        tbl[7] = '{32'h0000_1004, 32'd31,  0, 0, 1'b0, 1, 3,  32'h0000_1000, 2,  1'b0, -1};
        tbl[8] = '{32'h0000_2000, 32'd0,   0, 0, 1'b0, 0, 0,  32'h0,         0,  1'b0, 1};

        Rst_n = 1'b0; Go = 1'b0; Source_address = '0; Length = '0;
        repeat (2) @(negedge Clk);
        #1;
        check("rst busy", Busy, 1'b0);
        check("rst done", Done, 1'b0);
        check("rst error", Error, 1'b0);
        check("rst arvalid", bus.m_memory_arvalid, 1'b0);
        check("rst araddr", bus.m_memory_araddr, 32'h0);
        check("rst arlen", bus.m_memory_arlen, 4'h0);
        check("rst out_valid", bus.Out_valid, 1'b0);
        check("rst arsize", bus.m_memory_arsize, 3'b011);
        check("rst arburst", bus.m_memory_arburst, 2'b01);
        check("rst arcache", bus.m_memory_arcache, 4'b0011);
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_xfer(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 20; i++) begin
            rv.byte_addr = $urandom();
            if (i % 3 == 0) rv.byte_addr[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
            rv.len = $urandom_range(0, 600);
            rv.mode = $urandom_range(0, 2);
            rv.err_beat = (i % 4 == 1 && rv.len >= 8) ? int'($urandom_range(1, rv.len / 8)) : 0;
            rv.go_again = 1'b0; rv.exp_ars = -1; rv.exp_beats = -1;
            rv.exp_ar0_addr = '0; rv.exp_ar0_len = 0; rv.exp_err = 1'b0; rv.exp_busy = -1;
            run_xfer(rv, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a burst.
        clear_logs();
        ready_mode = 0; err_beat = 0; agent_en = 1;
        @(negedge Clk);
        Source_address = 30'h0000_0800; Length = 32'd128; Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        got5 = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge Clk); #2;
            if (beat_q.size() >= 5) begin got5 = 1; break; end
        end
        check("midrst reached_beat5", got5, 1'b1);
        agent_en = 0;
        Rst_n = 1'b0;
        #1;
        check("midrst busy", Busy, 1'b0);
        check("midrst done", Done, 1'b0);
        check("midrst error", Error, 1'b0);
        check("midrst arvalid", bus.m_memory_arvalid, 1'b0);
        check("midrst rready", bus.m_memory_rready, 1'b0);
        check("midrst out_valid", bus.Out_valid, 1'b0);
        check("midrst out_last", bus.Out_last, 1'b0);
        check("midrst araddr", bus.m_memory_araddr, 32'h0);
        check("midrst arlen", bus.m_memory_arlen, 4'h0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        run_xfer(tbl[1], "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
